// File: rtl/checker_pkg.sv
// Shared types for the end-of-run architectural state checker.
package checker_pkg;

    // Core configuration the checker is sized against by default.
    localparam int CORE_TAG_W   = 5;
    localparam int CHK_NUM_AREG = 8;
    localparam int CHK_DATA_W   = 16;
    localparam int CHK_IDX_W    = $clog2(CHK_NUM_AREG);
    localparam int CHK_CNT_W    = $clog2(CHK_NUM_AREG + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // Accumulated verdict: mismatch count plus the first offending register.
    typedef struct packed {
        logic [CHK_CNT_W-1:0]  cnt;
        logic                  valid;
        logic [CHK_IDX_W-1:0]  idx;
        logic [CHK_DATA_W-1:0] got;
        logic [CHK_DATA_W-1:0] exp;
    } chk_result_t;

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector. The history flop always tracks the input,
// so an edge masked by clear_i is consumed rather than deferred.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_d, sig_q;

    // History follows the input unconditionally.
    always_comb begin
        sig_d = sig_i;
    end

    // History register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_d;
    end

    assign rise_o = sig_i & ~sig_q & ~clear_i;

endmodule

// File: rtl/arch_state_checker.sv
// End-of-run checker: after stop, drain, then walk every architectural
// register through RAT -> PRF and compare against a reference ROM.
module arch_state_checker
    import checker_pkg::*;
#(
    parameter int NUM_AREG     = CHK_NUM_AREG,
    parameter int DATA_W       = CHK_DATA_W,
    parameter int TAG_W        = CORE_TAG_W,
    parameter int DRAIN_CYCLES = 4,
    parameter int IDX_W        = $clog2(NUM_AREG)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stop,
    input  logic                            clear_i,
    output logic [IDX_W-1:0]                rat_areg_o,
    input  logic [TAG_W-1:0]                rat_tag_i,
    output logic [TAG_W-1:0]                prf_addr_o,
    input  logic [DATA_W-1:0]               prf_data_i,
    output logic [IDX_W-1:0]                ref_idx_o,
    input  logic [DATA_W-1:0]               ref_data_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            pass_o,
    output logic [$clog2(NUM_AREG+1)-1:0]   err_cnt_o,
    output logic                            first_err_valid_o,
    output logic [IDX_W-1:0]                first_err_idx_o,
    output logic [DATA_W-1:0]               first_err_got_o,
    output logic [DATA_W-1:0]               first_err_exp_o
);

    // scan_idx needs one extra value so "all issued" is representable.
    localparam int CNT_W = $clog2(NUM_AREG + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    chk_state_t        state_d, state_q;
    logic [DRN_W-1:0]  drain_cnt_d, drain_cnt_q;
    logic [CNT_W-1:0]  scan_idx_d, scan_idx_q;
    logic              vld_d, vld_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic [TAG_W-1:0]  tag_d, tag_q;
    chk_result_t       res_d, res_q;
    logic              busy_d, busy_q, done_d, done_q, pass_d, pass_q;
    logic              stop_rise, issue;

    edge_detect_rise u_stop_edge (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .sig_i   (stop),
        .rise_o  (stop_rise)
    );

    // Next-state, two-stage scan pipeline, compare and read-port muxing.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        scan_idx_d  = scan_idx_q;
        vld_d       = 1'b0;
        idx_d       = idx_q;
        tag_d       = tag_q;
        res_d       = res_q;
        rat_areg_o  = '0;
        prf_addr_o  = '0;
        ref_idx_o   = '0;
        issue       = (state_q == ST_SCAN) && (scan_idx_q < CNT_W'(NUM_AREG));

        case (state_q)
            ST_IDLE: begin
                if (stop_rise) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DRN_W'(1);
                if (drain_cnt_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                    state_d    = ST_SCAN;
                    scan_idx_d = '0;
                end
            end
            ST_SCAN: begin
                // Stage A: RAT lookup, register index and tag.
                if (issue) begin
                    rat_areg_o = scan_idx_q[IDX_W-1:0];
                    idx_d      = scan_idx_q[IDX_W-1:0];
                    tag_d      = rat_tag_i;
                    vld_d      = 1'b1;
                    scan_idx_d = scan_idx_q + CNT_W'(1);
                end
                // Stage B: PRF and reference read, compare.
                if (vld_q) begin
                    prf_addr_o = tag_q;
                    ref_idx_o  = idx_q;
                    if (prf_data_i != ref_data_i) begin
                        res_d.cnt = res_q.cnt + CHK_CNT_W'(1);
                        if (!res_q.valid) begin
                            res_d.valid = 1'b1;
                            res_d.idx   = idx_q;
                            res_d.got   = prf_data_i;
                            res_d.exp   = ref_data_i;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_AREG - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        if (clear_i) begin
            state_d     = ST_IDLE;
            res_d       = '0;
            vld_d       = 1'b0;
            drain_cnt_d = '0;
            scan_idx_d  = '0;
        end

        busy_d = (state_d == ST_DRAIN) || (state_d == ST_SCAN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (res_d.cnt == '0);
    end

    // State, pipeline and result registers; status outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            scan_idx_q  <= '0;
            vld_q       <= 1'b0;
            idx_q       <= '0;
            tag_q       <= '0;
            res_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            scan_idx_q  <= scan_idx_d;
            vld_q       <= vld_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            res_q       <= res_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign err_cnt_o         = res_q.cnt;
    assign first_err_valid_o = res_q.valid;
    assign first_err_idx_o   = res_q.idx;
    assign first_err_got_o   = res_q.got;
    assign first_err_exp_o   = res_q.exp;

endmodule

// File: tb/tb_arch_state_checker.sv
// Randomized bench for arch_state_checker against a list-walking reference.
module tb_arch_state_checker;

    localparam int N        = 8;
    localparam int DW       = 16;
    localparam int TW       = 5;
    localparam int DC       = 4;
    localparam int IW       = 3;
    localparam int DONE_LAT = DC + N + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stop = 1'b0;
    logic          clear_i = 1'b0;
    logic [IW-1:0] rat_areg_o, ref_idx_o, first_err_idx_o;
    logic [TW-1:0] rat_tag_i, prf_addr_o;
    logic [DW-1:0] prf_data_i, ref_data_i, first_err_got_o, first_err_exp_o;
    logic          busy_o, done_o, pass_o, first_err_valid_o;
    logic [3:0]    err_cnt_o;

    logic [TW-1:0] rat_m [N];
    logic [DW-1:0] prf_m [32];
    logic [DW-1:0] ref_m [N];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rat_tag_i  = rat_m[rat_areg_o];
    assign prf_data_i = prf_m[prf_addr_o];
    assign ref_data_i = ref_m[ref_idx_o];

    arch_state_checker #(.NUM_AREG(N), .DATA_W(DW), .TAG_W(TW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .stop(stop), .clear_i(clear_i),
        .rat_areg_o(rat_areg_o), .rat_tag_i(rat_tag_i),
        .prf_addr_o(prf_addr_o), .prf_data_i(prf_data_i),
        .ref_idx_o(ref_idx_o), .ref_data_i(ref_data_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
        .first_err_valid_o(first_err_valid_o), .first_err_idx_o(first_err_idx_o),
        .first_err_got_o(first_err_got_o), .first_err_exp_o(first_err_exp_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk registers in order, list mismatches, keep the first.
    task automatic check_result(input string tag);
        int cnt = 0;
        int fidx = 0;
        logic [DW-1:0] fgot = '0, fexp = '0;
        for (int i = 0; i < N; i++) begin
            if (prf_m[rat_m[i]] != ref_m[i]) begin
                if (cnt == 0) begin
                    fidx = i; fgot = prf_m[rat_m[i]]; fexp = ref_m[i];
                end
                cnt++;
            end
        end
        chk({tag, ".done"},  32'(done_o), 32'd1);
        chk({tag, ".busy"},  32'(busy_o), 32'd0);
        chk({tag, ".pass"},  32'(pass_o), (cnt == 0) ? 32'd1 : 32'd0);
        chk({tag, ".cnt"},   32'(err_cnt_o), 32'(cnt));
        chk({tag, ".fvld"},  32'(first_err_valid_o), (cnt != 0) ? 32'd1 : 32'd0);
        chk({tag, ".fidx"},  32'(first_err_idx_o), 32'(fidx));
        chk({tag, ".fgot"},  32'(first_err_got_o), 32'(fgot));
        chk({tag, ".fexp"},  32'(first_err_exp_o), 32'(fexp));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy_o), 32'd0);
        chk({tag, ".done"}, 32'(done_o), 32'd0);
        chk({tag, ".pass"}, 32'(pass_o), 32'd0);
        chk({tag, ".cnt"},  32'(err_cnt_o), 32'd0);
        chk({tag, ".fvld"}, 32'(first_err_valid_o), 32'd0);
        chk({tag, ".fgot"}, 32'(first_err_got_o), 32'd0);
        chk({tag, ".rat"},  32'(rat_areg_o), 32'd0);
    endtask

    // Random tags and data; each reference entry is corrupted with p=1/4.
    task automatic rand_setup();
        for (int t = 0; t < 32; t++) prf_m[t] = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            rat_m[i] = TW'($urandom_range(31, 0));
            ref_m[i] = prf_m[rat_m[i]];
            if ($urandom_range(3, 0) == 0) ref_m[i] = ref_m[i] ^ DW'($urandom_range(65535, 1));
        end
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk); clear_i = 1'b1;
        @(negedge clk); clear_i = 1'b0;
        check_idle(tag);
    endtask

    // Raise stop, follow the scan addresses cycle by cycle, wait for done.
    task automatic run(input string tag, input bit glitch);
        int c = 0;
        @(negedge clk); stop = 1'b1;
        @(posedge clk); #1;
        if (glitch) stop = 1'b0;
        while (c < 40) begin
            @(posedge clk); #1; c++;
            if (c == 1) chk({tag, ".busy1"}, 32'(busy_o), 32'd1);
            if (c >= DC && c < DC + N)
                chk({tag, ".rat_idx"}, 32'(rat_areg_o), 32'(c - DC));
            if (c >= DC + 1 && c <= DC + N) begin
                chk({tag, ".prf_addr"}, 32'(prf_addr_o), 32'(rat_m[c - DC - 1]));
                chk({tag, ".ref_idx"}, 32'(ref_idx_o), 32'(c - DC - 1));
            end
            if (done_o) break;
        end
        chk({tag, ".latency"}, 32'(c), 32'(DONE_LAT));
        check_result(tag);
        @(negedge clk); stop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;
        for (int t = 0; t < 32; t++) prf_m[t] = '0;
        for (int i = 0; i < N; i++) begin rat_m[i] = '0; ref_m[i] = '0; end
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // All registers match through an identity RAT.
        for (int i = 0; i < N; i++) begin
            rat_m[i] = TW'(i); prf_m[i] = DW'(i + 1); ref_m[i] = DW'(i + 1);
        end
        run("allmatch", 1'b0);
        do_clear("clr1");

        // Two mismatches: areg 3 via tag 17, and areg 6.
        rat_m[3] = 5'd17; prf_m[17] = 16'h00AA; ref_m[3] = 16'h00AB;
        ref_m[6] = prf_m[6] ^ 16'h0100;
        run("twomis", 1'b0);
        do_clear("clr2");

        // Renamed mapping areg i -> tag 31-i.
        for (int t = 0; t < 32; t++) prf_m[t] = DW'($urandom);
        for (int i = 0; i < N; i++) begin rat_m[i] = TW'(31 - i); ref_m[i] = prf_m[31 - i]; end
        run("renamed", 1'b0);
        do_clear("clr3");

        // Single-cycle stop pulse, then an ignored edge while in DONE.
        rand_setup();
        run("glitch", 1'b1);
        @(negedge clk); stop = 1'b1;
        repeat (2) @(negedge clk); stop = 1'b0;
        repeat (3) @(negedge clk);
        check_result("done_edge");
        do_clear("clr4");

        // Clear coincident with a stop edge consumes it; held stop does not re-arm.
        @(negedge clk); clear_i = 1'b1; stop = 1'b1;
        @(negedge clk); clear_i = 1'b0;
        repeat (4) @(negedge clk);
        check_idle("clr_edge");
        stop = 1'b0;
        @(negedge clk);
        rand_setup();
        run("rearm", 1'b0);
        do_clear("clr5");

        // Reset in the middle of SCAN at index 4.
        rand_setup();
        @(negedge clk); stop = 1'b1;
        c = 0;
        while (c < 30) begin
            @(posedge clk); #1; c++;
            if (busy_o && rat_areg_o == 3'd4) break;
        end
        chk("midscan.reach", 32'(rat_areg_o), 32'd4);
        rst = 1'b1; #1;
        check_idle("midscan.rst");
        @(negedge clk); rst = 1'b0; stop = 1'b0;
        @(negedge clk);
        rand_setup();
        run("after_rst", 1'b0);
        do_clear("clr6");

        // Random programs back to back.
        for (int k = 0; k < 6; k++) begin
            rand_setup();
            run($sformatf("rand%0d", k), ($urandom_range(1, 0) == 1));
            do_clear($sformatf("rclr%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
